pipe5_fwd_core: RTL and testbench

Parametrised five-stage (IF/ID/EXE/MEM/WB) pipelined integer core. It succeeds the fixed-width pipelined top level and adds operand forwarding, load-use interlock, branch flush and a bypassing register file. Instruction and data memories sit outside the block behind combinational-read ports. The block is the CPU datapath and control instantiated by the SoC top.

---
 rtl/pipe5_pkg.sv | 37 +++
 rtl/pipe5_bypass_regfile.sv | 37 +++
 rtl/pipe5_fwd_core.sv | 222 ++++++++++++++++++++++
 tb/tb_pipe5_fwd_core.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe5_pkg.sv
// Shared opcode/funct constants, ALU operation enum and ID-stage control bundle
// for the five-stage core.
package pipe5_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_PASS
  } alu_op_e;

  // Width-independent control decoded in ID; data-carrying stage records are
  // declared in the core where the width parameters are known.
  typedef struct packed {
    logic    wen;
    logic    mem_rd;
    logic    mem_wr;
    logic    is_br;
    logic    use_imm;
    alu_op_e alu_op;
  } id_ctrl_t;

endpackage

// File: rtl/pipe5_bypass_regfile.sv
// 2^ASIZE x DSIZE register file, two read ports, one write port, with
// write-through bypass to same-cycle reads; register 0 always reads zero.
module pipe5_bypass_regfile #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ASIZE-1:0] raddr_a,
  output logic [DSIZE-1:0] rdata_a,
  input  logic [ASIZE-1:0] raddr_b,
  output logic [DSIZE-1:0] rdata_b,
  input  logic             wen,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata
);

  localparam int NREG = 1 << ASIZE;

  logic [DSIZE-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wen && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (raddr_a != '0) rdata_a = (wen && waddr == raddr_a) ? wdata : regs[raddr_a];
    if (raddr_b != '0) rdata_b = (wen && waddr == raddr_b) ? wdata : regs[raddr_b];
  end

endmodule

// File: rtl/pipe5_fwd_core.sv
// Five-stage IF/ID/EXE/MEM/WB integer core with branch flush in EXE.
// PIPE_FWD_EN selects operand forwarding + 1-cycle load-use interlock; otherwise RAW stalls.
module pipe5_fwd_core
  import pipe5_pkg::*;
#(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5,
  parameter int ISIZE = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [ISIZE-1:0] imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [DSIZE-1:0] dmem_addr,
  output logic [DSIZE-1:0] dmem_wdata,
  output logic             dmem_wen,
  output logic             dmem_ren,
  input  logic [DSIZE-1:0] dmem_rdata,
  output logic             wb_wen,
  output logic [ASIZE-1:0] wb_waddr,
  output logic [DSIZE-1:0] wb_wdata,
  output logic             stall,
  output logic             flush
);

  typedef struct packed {
    logic             v;
    logic [ISIZE-1:0] pc;
    logic [31:0]      instr;
  } ifid_t;

  typedef struct packed {
    logic             v;
    id_ctrl_t         ctrl;
    logic [ISIZE-1:0] pc;
    logic [15:0]      imm;
    logic [DSIZE-1:0] a;
    logic [DSIZE-1:0] b;
    logic [ASIZE-1:0] waddr;
  } idex_t;

  typedef struct packed {
    logic             v;
    logic             wen;
    logic             mem_rd;
    logic             mem_wr;
    logic [ASIZE-1:0] waddr;
    logic [DSIZE-1:0] alu;
    logic [DSIZE-1:0] sdata;
  } exmem_t;

  typedef struct packed {
    logic             v;
    logic             wen;
    logic [ASIZE-1:0] waddr;
    logic [DSIZE-1:0] wdata;
  } memwb_t;

  logic [ISIZE-1:0] pc;
  ifid_t  ifid;
  idex_t  idex;
  exmem_t exmem;
  memwb_t memwb;

  logic [ASIZE-1:0] id_rs, id_rt, id_waddr;
  logic [DSIZE-1:0] id_a, id_b;
  id_ctrl_t         id_ctrl;
  logic [DSIZE-1:0] ex_a, ex_b, ex_b_op, ex_imm, ex_res;
  logic             br_taken, hazard;
  logic [ISIZE-1:0] br_target;

  assign id_rs = ASIZE'(ifid.instr[25:21]);
  assign id_rt = ASIZE'(ifid.instr[20:16]);

  always_comb begin
    id_ctrl.wen     = 1'b0;
    id_ctrl.mem_rd  = 1'b0;
    id_ctrl.mem_wr  = 1'b0;
    id_ctrl.is_br   = 1'b0;
    id_ctrl.use_imm = 1'b0;
    id_ctrl.alu_op  = ALU_ADD;
    id_waddr        = id_rt;
    case (ifid.instr[31:26])
      OP_RTYPE: begin
        id_waddr    = ASIZE'(ifid.instr[15:11]);
        id_ctrl.wen = 1'b1;
        case (ifid.instr[5:0])
          FN_ADD:  id_ctrl.alu_op = ALU_ADD;
          FN_SUB:  id_ctrl.alu_op = ALU_SUB;
          FN_AND:  id_ctrl.alu_op = ALU_AND;
          FN_OR:   id_ctrl.alu_op = ALU_OR;
          FN_SLT:  id_ctrl.alu_op = ALU_SLT;
          default: id_ctrl.wen    = 1'b0;
        endcase
      end
      OP_ADDI: begin
        id_ctrl.wen     = 1'b1;
        id_ctrl.use_imm = 1'b1;
      end
      OP_LW: begin
        id_ctrl.wen     = 1'b1;
        id_ctrl.mem_rd  = 1'b1;
        id_ctrl.use_imm = 1'b1;
      end
      OP_SW: begin
        id_ctrl.mem_wr  = 1'b1;
        id_ctrl.use_imm = 1'b1;
      end
      OP_BEQ:  id_ctrl.is_br = 1'b1;
      default: ;
    endcase
    // r0 writes are dropped at decode so they never retire or forward
    if (id_waddr == '0) id_ctrl.wen = 1'b0;
  end

  pipe5_bypass_regfile #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_rf (
    .clk     (clk),
    .rst_n   (rst),
    .raddr_a (id_rs),
    .rdata_a (id_a),
    .raddr_b (id_rt),
    .rdata_b (id_b),
    .wen     (wb_wen),
    .waddr   (wb_waddr),
    .wdata   (wb_wdata)
  );

`ifdef PIPE_FWD_EN
  logic [ASIZE-1:0] idex_rs, idex_rt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idex_rs <= '0;
      idex_rt <= '0;
    end else begin
      idex_rs <= id_rs;
      idex_rt <= id_rt;
    end
  end

  // MEM/WB applied first so the younger EXE/MEM result overrides it
  always_comb begin
    ex_a = idex.a;
    ex_b = idex.b;
    if (memwb.v && memwb.wen && memwb.waddr != '0) begin
      if (memwb.waddr == idex_rs) ex_a = memwb.wdata;
      if (memwb.waddr == idex_rt) ex_b = memwb.wdata;
    end
    if (exmem.v && exmem.wen && exmem.waddr != '0) begin
      if (exmem.waddr == idex_rs) ex_a = exmem.alu;
      if (exmem.waddr == idex_rt) ex_b = exmem.alu;
    end
  end

  assign hazard = ifid.v && idex.v && idex.ctrl.mem_rd &&
                  (idex_rt == id_rs || idex_rt == id_rt);
`else
  assign ex_a = idex.a;
  assign ex_b = idex.b;

  assign hazard = ifid.v &&
    ((idex.v && idex.ctrl.wen && idex.waddr != '0 &&
      (idex.waddr == id_rs || idex.waddr == id_rt)) ||
     (exmem.v && exmem.wen && exmem.waddr != '0 &&
      (exmem.waddr == id_rs || exmem.waddr == id_rt)));
`endif

  assign ex_imm  = DSIZE'($signed(idex.imm));
  assign ex_b_op = idex.ctrl.use_imm ? ex_imm : ex_b;

  always_comb begin
    case (idex.ctrl.alu_op)
      ALU_ADD: ex_res = ex_a + ex_b_op;
      ALU_SUB: ex_res = ex_a - ex_b_op;
      ALU_AND: ex_res = ex_a & ex_b_op;
      ALU_OR:  ex_res = ex_a | ex_b_op;
      ALU_SLT: ex_res = ($signed(ex_a) < $signed(ex_b_op)) ? DSIZE'(1) : '0;
      default: ex_res = ex_b_op;
    endcase
  end

  assign br_taken  = idex.v && idex.ctrl.is_br && (ex_a == ex_b);
  assign br_target = idex.pc + ISIZE'(1) + ISIZE'($signed(idex.imm));
  assign flush     = br_taken;
  assign stall     = hazard && !br_taken;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc    <= '0;
      ifid  <= '0;
      idex  <= '0;
      exmem <= '0;
      memwb <= '0;
    end else begin
      if (br_taken)    pc <= br_target;
      else if (!stall) pc <= pc + ISIZE'(1);

      if (br_taken)    ifid.v <= 1'b0;
      else if (!stall) ifid   <= '{v: 1'b1, pc: pc, instr: imem_rdata};

      if (br_taken || stall) idex.v <= 1'b0;
      else idex <= '{v: ifid.v, ctrl: id_ctrl, pc: ifid.pc, imm: ifid.instr[15:0],
                     a: id_a, b: id_b, waddr: id_waddr};

      exmem <= '{v: idex.v, wen: idex.ctrl.wen, mem_rd: idex.ctrl.mem_rd,
                 mem_wr: idex.ctrl.mem_wr, waddr: idex.waddr, alu: ex_res, sdata: ex_b};

      memwb <= '{v: exmem.v, wen: exmem.wen, waddr: exmem.waddr,
                 wdata: exmem.mem_rd ? dmem_rdata : exmem.alu};
    end
  end

  assign imem_addr  = pc;
  assign dmem_addr  = exmem.alu;
  assign dmem_wdata = exmem.sdata;
  assign dmem_wen   = exmem.v && exmem.mem_wr;
  assign dmem_ren   = exmem.v && exmem.mem_rd;
  assign wb_wen     = memwb.v && memwb.wen;
  assign wb_waddr   = memwb.waddr;
  assign wb_wdata   = memwb.wdata;

endmodule

// File: tb/tb_pipe5_fwd_core.sv
// Directed-program bench for pipe5_fwd_core; stall expectations follow PIPE_FWD_EN.
module tb_pipe5_fwd_core;

  localparam logic [5:0] OPC_ADDI = 6'b001000;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] F_ADD    = 6'b100000;

`ifdef PIPE_FWD_EN
  localparam int RAW_GAP = 1, RAW_STALLS = 0, LU_STALLS = 1;
`else
  localparam int RAW_GAP = 3, RAW_STALLS = 4, LU_STALLS = 4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_wen, dmem_ren;
  logic        wb_wen, stall, flush;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;

  logic [31:0] imem [64];
  logic [31:0] dmem [16];

  int n_vec = 0;
  int n_err = 0;

  int   fetch [32];
  logic wen_tr [32];
  int   ret_a [$], ret_d [$], ret_c [$], wr_a [$], wr_d [$];
  int   stall_n, flush_n, flush_cyc, ren_n;
  logic seen;

  pipe5_fwd_core #(.DSIZE(32), .ASIZE(5), .ISIZE(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wen   (dmem_wen),
    .dmem_ren   (dmem_ren),
    .dmem_rdata (dmem_rdata),
    .wb_wen     (wb_wen),
    .wb_waddr   (wb_waddr),
    .wb_wdata   (wb_wdata),
    .stall      (stall),
    .flush      (flush)
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem[imem_addr[5:0]];
  assign dmem_rdata = dmem[dmem_addr[3:0]];

  always @(posedge clk) if (dmem_wen) dmem[dmem_addr[3:0]] <= dmem_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, logic [5:0] fn);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, fn};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Cycle 0 is the cycle in which reset has just been released.
  task automatic run(input int ncyc);
    ret_a.delete(); ret_d.delete(); ret_c.delete(); wr_a.delete(); wr_d.delete();
    stall_n = 0; flush_n = 0; flush_cyc = -1; ren_n = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      fetch[c]  = imem_addr;
      wen_tr[c] = wb_wen;
      if (wb_wen) begin
        ret_a.push_back(int'(wb_waddr));
        ret_d.push_back(wb_wdata);
        ret_c.push_back(c);
      end
      if (stall) stall_n++;
      if (flush) begin flush_n++; flush_cyc = c; end
      if (dmem_wen) begin wr_a.push_back(dmem_addr); wr_d.push_back(dmem_wdata); end
      if (dmem_ren) ren_n++;
    end
  endtask

  task automatic check_ret(input string tag, input int k, input int a, input int d);
    if (ret_a.size() > k) begin
      check($sformatf("%s_waddr", tag), ret_a[k], a);
      check($sformatf("%s_wdata", tag), ret_d[k], d);
    end
  endtask

  initial begin
    clear_imem();
    #2 rst = 1'b0;
    #1;
    check("rst_pc", imem_addr, 0);
    check("rst_wb_wen", wb_wen, 0);
    check("rst_dmem_wen", dmem_wen, 0);
    check("rst_dmem_ren", dmem_ren, 0);
    check("rst_stall", stall, 0);
    check("rst_flush", flush, 0);

    // Independent addi stream: linear fetch, first retirement at cycle 4
    for (int k = 0; k < 4; k++) imem[k] = enc_i(OPC_ADDI, 0, k + 1, k + 1);
    do_reset();
    run(8);
    for (int c = 0; c < 6; c++) check($sformatf("fetch_c%0d", c), fetch[c], c);
    for (int c = 0; c < 4; c++) check($sformatf("early_wen_c%0d", c), wen_tr[c], 0);
    check("first_wen_c4", wen_tr[4], 1);
    check_ret("first_ret", 0, 1, 1);
    check("indep_stalls", stall_n, 0);
    check("indep_flushes", flush_n, 0);

    // RAW chain
    clear_imem();
    imem[0] = enc_i(OPC_ADDI, 0, 1, 5);
    imem[1] = enc_r(1, 1, 2, F_ADD);
    imem[2] = enc_r(2, 1, 3, F_ADD);
    do_reset();
    run(16);
    check("raw_nret", ret_a.size(), 3);
    check_ret("raw_r1", 0, 1, 5);
    check_ret("raw_r2", 1, 2, 10);
    check_ret("raw_r3", 2, 3, 15);
    if (ret_c.size() == 3) begin
      check("raw_c0", ret_c[0], 4);
      check("raw_gap1", ret_c[1] - ret_c[0], RAW_GAP);
      check("raw_gap2", ret_c[2] - ret_c[1], RAW_GAP);
    end
    check("raw_stalls", stall_n, RAW_STALLS);

    // Store, load, load-use
    clear_imem();
    imem[0] = enc_i(OPC_ADDI, 0, 4, 9);
    imem[1] = enc_i(OPC_SW, 0, 4, 3);
    imem[2] = enc_i(OPC_LW, 0, 5, 3);
    imem[3] = enc_r(5, 4, 6, F_ADD);
    do_reset();
    run(20);
    check("lu_nwr", wr_a.size(), 1);
    if (wr_a.size() > 0) begin
      check("lu_st_addr", wr_a[0], 3);
      check("lu_st_data", wr_d[0], 9);
    end
    check("lu_nren", ren_n, 1);
    check("lu_stalls", stall_n, LU_STALLS);
    check("lu_nret", ret_a.size(), 3);
    check_ret("lu_r4", 0, 4, 9);
    check_ret("lu_r5", 1, 5, 9);
    check_ret("lu_r6", 2, 6, 18);

    // Not-taken beq at 4, taken beq at 8 -> 11
    clear_imem();
    imem[0]  = enc_i(OPC_ADDI, 0, 1, 1);
    imem[4]  = enc_i(OPC_BEQ, 1, 0, 5);
    imem[8]  = enc_i(OPC_BEQ, 0, 0, 2);
    imem[9]  = enc_i(OPC_ADDI, 0, 9, 9);
    imem[10] = enc_i(OPC_ADDI, 0, 10, 10);
    imem[11] = enc_i(OPC_ADDI, 0, 11, 11);
    do_reset();
    run(20);
    check("br_flushes", flush_n, 1);
    check("br_flush_cyc", flush_cyc, 10);
    check("br_fetch_c10", fetch[10], 10);
    check("br_fetch_c11", fetch[11], 11);
    check("br_fetch_c12", fetch[12], 12);
    check("br_nret", ret_a.size(), 2);
    check_ret("br_r1", 0, 1, 1);
    check_ret("br_r11", 1, 11, 11);
    if (ret_c.size() == 2) check("br_r11_cyc", ret_c[1], 15);

    // Register 0
    clear_imem();
    imem[0] = enc_i(OPC_ADDI, 0, 0, 7);
    imem[1] = enc_r(0, 0, 7, F_ADD);
    do_reset();
    run(10);
    check("r0_nret", ret_a.size(), 1);
    check_ret("r0_r7", 0, 7, 0);
    check("r0_stalls", stall_n, 0);

    // Reset during a load-use stall
    clear_imem();
    imem[0] = enc_i(OPC_ADDI, 0, 4, 9);
    imem[4] = enc_i(OPC_LW, 0, 5, 3);
    imem[5] = enc_r(5, 4, 6, F_ADD);
    do_reset();
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (stall) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("mr_stall_seen", seen, 1);
    #1 rst = 1'b0;
    #1;
    check("mr_pc", imem_addr, 0);
    check("mr_stall", stall, 0);
    check("mr_flush", flush, 0);
    check("mr_wb_wen", wb_wen, 0);
    check("mr_dmem_wen", dmem_wen, 0);
    check("mr_dmem_ren", dmem_ren, 0);
    clear_imem();
    imem[0] = enc_r(4, 4, 8, F_ADD);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    run(8);
    check("mr_fetch_c0", fetch[0], 0);
    check("mr_nret", ret_a.size(), 1);
    check_ret("mr_r8", 0, 8, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
